axi4_m_rd_burst_gen: RTL and testbench

- Read-request engine directly upstream of the AXI4 master read-channel FIFO pair.
- Accepts one block-read command (start address, beat count) and splits it into legal INCR bursts, capped at MAX_LEN and never crossing a 4 KB boundary.
- Pushes the bursts into the AR FIFO write port and drains R beats from the R FIFO read port.
- Presents the returned data as a valid/ready stream, with completion and error status.

---
 rtl/axi4_m_rd_pkg.sv | 21 ++
 rtl/axi4_burst_len_calc.sv | 27 ++
 rtl/axi4_m_rd_burst_gen.sv | 146 ++++++++++++++
 tb/tb_axi4_m_rd_burst_gen.sv | 239 +++++++++++++++++++++++
 4 files changed

// File: rtl/axi4_m_rd_pkg.sv
// Shared types and constants for the AXI4 master read-side request engine.
//   BURST_INCR : ARBURST encoding for incrementing bursts
//   RESP_OKAY  : RRESP encoding for a clean beat
//   state_e    : command FSM states
//   size_of()  : ARSIZE encoding for a bus width given in bytes
package axi4_m_rd_pkg;

  localparam logic [1:0] BURST_INCR = 2'b01;
  localparam logic [1:0] RESP_OKAY  = 2'b00;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_e;

  function automatic logic [2:0] size_of(input int n);
    logic [2:0] s;
    s = '0;
    for (int i = 0; i < 8; i++)
      if ((1 << i) == n) s = 3'(i);
    return s;
  endfunction

endpackage

// File: rtl/axi4_burst_len_calc.sv
// Combinational INCR burst length: the smallest of the beats still owed,
// MAX_LEN, and the beats left before the next 4 KB boundary.
//   addr      : low 12 bits of the next burst address (N-aligned)
//   remaining : beats still to be requested
//   len       : beats in the next burst (0 when remaining is 0)
module axi4_burst_len_calc #(
  parameter int N       = 8,
  parameter int MAX_LEN = 16
) (
  input  logic [11:0] addr,
  input  logic [15:0] remaining,
  output logic [8:0]  len
);
  localparam int SZ = $clog2(N);

  logic [12:0] to_bound;
  logic [15:0] l0, l1;

  always_comb begin
    // addr is N-aligned, so the byte distance divides exactly into beats
    to_bound = 13'(13'd4096 >> SZ) - 13'(addr >> SZ);
    l0  = (remaining < 16'(MAX_LEN)) ? remaining : 16'(MAX_LEN);
    l1  = (l0 < 16'(to_bound)) ? l0 : 16'(to_bound);
    len = 9'(l1);
  end

endmodule

// File: rtl/axi4_m_rd_burst_gen.sv
// Block-read engine in front of the AXI4 master AR/R FIFO pair.
// One command (start address, beat count) is split into INCR bursts that
// respect MAX_LEN and the 4 KB rule, pushed into the AR FIFO with at most
// MAX_OUT outstanding; returned R beats are passed straight through to a
// valid/ready stream.
//   cmd_*        : command handshake (accepted only in IDLE)
//   ar_*         : AR FIFO write port and burst fields
//   r_*          : R FIFO read port and beat fields
//   out_*        : returned data stream, out_last on the command's last beat
//   busy/done/err: status; err is sticky until the next accepted command
module axi4_m_rd_burst_gen
  import axi4_m_rd_pkg::*;
#(
  parameter int A       = 32,
  parameter int N       = 8,
  parameter int I       = 1,
  parameter int ID      = 0,
  parameter int MAX_LEN = 16,
  parameter int MAX_OUT = 4
) (
  input  logic           aclk,
  input  logic           aresetn,
  input  logic           cmd_valid,
  output logic           cmd_ready,
  input  logic [A-1:0]   cmd_addr,
  input  logic [15:0]    cmd_beats,
  input  logic           ar_wr_full,
  output logic           ar_wr_en,
  output logic [A-1:0]   ar_araddr,
  output logic [7:0]     ar_arlen,
  output logic [2:0]     ar_arsize,
  output logic [1:0]     ar_arburst,
  output logic [I-1:0]   ar_arid,
  input  logic           r_rd_empty,
  output logic           r_rd_en,
  input  logic [8*N-1:0] r_rdata,
  input  logic [1:0]     r_rresp,
  input  logic           r_rlast,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [8*N-1:0] out_data,
  output logic           out_last,
  output logic           busy,
  output logic           done,
  output logic           err
);
  localparam int          SZ   = $clog2(N);
  localparam int          OW   = $clog2(MAX_OUT + 1);
  localparam logic [2:0]  SIZE = size_of(N);

  state_e          state, state_nxt;
  logic [A-1:0]    addr_q;
  logic [15:0]     remaining, rx_cnt, beats_q;
  logic [OW-1:0]   outstanding;
  logic            err_q;
  logic [8:0]      len;
  logic            accept, push, pop;

  axi4_burst_len_calc #(.N(N), .MAX_LEN(MAX_LEN)) u_len (
    .addr      (addr_q[11:0]),
    .remaining (remaining),
    .len       (len)
  );

  // data side is a zero-latency pass-through of the R FIFO head
  assign busy      = (state != IDLE);
  assign out_valid = busy & ~r_rd_empty;
  assign out_data  = r_rdata;
  assign pop       = out_valid & out_ready;
  assign r_rd_en   = pop;
  assign out_last  = out_valid & (rx_cnt == beats_q - 16'd1);
  assign err       = err_q;

  // AR fields come straight from registered state, so they are settled
  // whenever ar_wr_en is raised
  assign ar_wr_en   = push;
  assign ar_araddr  = addr_q;
  assign ar_arlen   = 8'(len - 9'd1);
  assign ar_arsize  = SIZE;
  assign ar_arburst = BURST_INCR;
  assign ar_arid    = I'(ID);

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) state <= IDLE;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    cmd_ready = 1'b0;
    accept    = 1'b0;
    push      = 1'b0;
    done      = 1'b0;
    case (state)
      IDLE: begin
        cmd_ready = 1'b1;
        accept    = cmd_valid;
        if (cmd_valid) state_nxt = (cmd_beats == 16'd0) ? DONE : RUN;
      end
      RUN: begin
        push = (remaining != 16'd0) & ~ar_wr_full & (outstanding < OW'(MAX_OUT));
        // completion follows the beat count, not r_rlast
        if (out_last & out_ready) state_nxt = DONE;
      end
      DONE: begin
        done      = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      addr_q      <= '0;
      remaining   <= '0;
      beats_q     <= '0;
      rx_cnt      <= '0;
      outstanding <= '0;
      err_q       <= 1'b0;
    end else if (accept) begin
      addr_q      <= cmd_addr & ~A'(N - 1);
      remaining   <= cmd_beats;
      beats_q     <= cmd_beats;
      rx_cnt      <= '0;
      outstanding <= '0;
      err_q       <= 1'b0;
    end else begin
      if (push) begin
        addr_q    <= addr_q + (A'(len) << SZ);
        remaining <= remaining - 16'(len);
      end
      if (pop) begin
        rx_cnt <= rx_cnt + 16'd1;
        if (r_rresp != RESP_OKAY) err_q <= 1'b1;
      end
      // a push and a burst-closing pop in one cycle cancel out
      case ({push, pop & r_rlast})
        2'b10:   outstanding <= outstanding + OW'(1);
        2'b01:   outstanding <= outstanding - OW'(1);
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_axi4_m_rd_burst_gen.sv
// Directed bench for axi4_m_rd_burst_gen (N=8, MAX_LEN=16, MAX_OUT=2).
// A queue stands in for the AR/R FIFO pair and slave: each pushed AR
// appends its beats, data = beat byte address, one chosen address answers
// SLVERR. Pushes, pops and done pulses are logged at the clock edge and
// checked against hand-computed bursts after each command.
module tb_axi4_m_rd_burst_gen;

  logic        aclk = 1'b0;
  logic        aresetn;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [31:0] cmd_addr;
  logic [15:0] cmd_beats;
  logic        ar_wr_full;
  logic        ar_wr_en;
  logic [31:0] ar_araddr;
  logic [7:0]  ar_arlen;
  logic [2:0]  ar_arsize;
  logic [1:0]  ar_arburst;
  logic [0:0]  ar_arid;
  logic        r_rd_empty = 1'b1;
  logic        r_rd_en;
  logic [63:0] r_rdata = '0;
  logic [1:0]  r_rresp = '0;
  logic        r_rlast = 1'b0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [63:0] out_data;
  logic        out_last;
  logic        busy;
  logic        done;
  logic        err;

  axi4_m_rd_burst_gen #(.A(32), .N(8), .I(1), .ID(0), .MAX_LEN(16), .MAX_OUT(2)) dut (
    .aclk(aclk), .aresetn(aresetn),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_addr(cmd_addr), .cmd_beats(cmd_beats),
    .ar_wr_full(ar_wr_full), .ar_wr_en(ar_wr_en), .ar_araddr(ar_araddr), .ar_arlen(ar_arlen),
    .ar_arsize(ar_arsize), .ar_arburst(ar_arburst), .ar_arid(ar_arid),
    .r_rd_empty(r_rd_empty), .r_rd_en(r_rd_en), .r_rdata(r_rdata), .r_rresp(r_rresp),
    .r_rlast(r_rlast), .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_last(out_last), .busy(busy), .done(done), .err(err)
  );

  always #5 aclk = ~aclk;

  typedef struct { logic [63:0] data; logic [1:0] resp; logic last; } rbeat_t;
  typedef struct { logic [31:0] addr; logic [7:0] len; int pops; } ar_t;
  typedef struct { logic [63:0] data; logic last; logic err_b; } obeat_t;

  rbeat_t rq[$];
  ar_t    ar_log[$];
  obeat_t out_log[$];

  int          cnt_tot = 0;
  int          cnt_bad = 0;
  int          done_cnt = 0;
  int          full_viol = 0;
  int          dn0;
  logic        r_hold = 1'b0;
  logic        tog_en = 1'b0;
  logic        rdy_lvl = 1'b1;
  logic [31:0] err_addr = 32'hFFFF_FFFF;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    cnt_tot++;
    if (got !== exp) begin
      cnt_bad++;
      $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // slave / FIFO model, sampled at the active edge (inputs move on negedge)
  always @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      rq.delete();
    end else begin
      if (ar_wr_en && ar_wr_full) full_viol <= full_viol + 1;
      if (ar_wr_en && !ar_wr_full) begin
        ar_log.push_back('{ar_araddr, ar_arlen, out_log.size()});
        for (int k = 0; k <= int'(ar_arlen); k++)
          rq.push_back('{64'(ar_araddr) + 64'(k * 8),
                         ((ar_araddr + 32'(k * 8)) == err_addr) ? 2'b10 : 2'b00,
                         (k == int'(ar_arlen))});
      end
      if (out_valid && out_ready) out_log.push_back('{out_data, out_last, err});
      if (r_rd_en && rq.size() > 0) rq.delete(0);
      if (done) done_cnt <= done_cnt + 1;
    end
  end

  always @(negedge aclk) begin
    r_rd_empty = r_hold || (rq.size() == 0);
    if (rq.size() > 0) begin
      r_rdata = rq[0].data; r_rresp = rq[0].resp; r_rlast = rq[0].last;
    end else begin
      r_rdata = '0; r_rresp = '0; r_rlast = 1'b0;
    end
    out_ready = tog_en ? ~out_ready : rdy_lvl;
  end

  // present one command for one cycle; DUT is IDLE so it is taken at once
  task automatic issue(input logic [31:0] a, input logic [15:0] b);
    @(negedge aclk);
    ar_log.delete(); out_log.delete(); dn0 = done_cnt;
    cmd_valid = 1'b1; cmd_addr = a; cmd_beats = b;
    @(negedge aclk);
    cmd_valid = 1'b0;
  endtask

  task automatic wait_done(input string tag, input int budget);
    int n = 0;
    while (done_cnt == dn0 && n < budget) begin @(negedge aclk); n++; end
    chk(tag, 64'(done_cnt - dn0), 64'd1);
  endtask

  task automatic chk_ar(input int idx, input logic [31:0] a, input logic [7:0] l);
    if (ar_log.size() > idx) begin
      chk($sformatf("ar%0d_addr", idx), 64'(ar_log[idx].addr), 64'(a));
      chk($sformatf("ar%0d_len", idx), 64'(ar_log[idx].len), 64'(l));
    end else chk($sformatf("ar%0d_present", idx), 64'(ar_log.size()), 64'(idx + 1));
  endtask

  task automatic chk_data(input string tag, input logic [31:0] base, input int n);
    chk({tag, "_nbeats"}, 64'(out_log.size()), 64'(n));
    for (int k = 0; k < n && k < out_log.size(); k++) begin
      chk($sformatf("%s_d%0d", tag, k), out_log[k].data, 64'(base) + 64'(k * 8));
      chk($sformatf("%s_l%0d", tag, k), 64'(out_log[k].last), 64'(k == n - 1));
    end
  endtask

  initial begin
    aresetn = 1'b0; cmd_valid = 1'b0; cmd_addr = '0; cmd_beats = '0; ar_wr_full = 1'b0;
    #3;
    chk("rst_busy", 64'(busy), 0);
    chk("rst_done", 64'(done), 0);
    chk("rst_err", 64'(err), 0);
    chk("rst_arwr", 64'(ar_wr_en), 0);
    chk("rst_cmdrdy", 64'(cmd_ready), 1);
    repeat (2) @(negedge aclk);
    aresetn = 1'b1;

    // single aligned burst
    issue(32'h1000, 16'd4);
    wait_done("t1_done", 100);
    chk_ar(0, 32'h1000, 8'd3);
    chk("t1_nar", 64'(ar_log.size()), 1);
    chk("t1_size", 64'(ar_arsize), 3);
    chk("t1_burst", 64'(ar_arburst), 1);
    chk_data("t1", 32'h1000, 4);
    chk("t1_err", 64'(err), 0);
    repeat (3) @(negedge aclk);
    chk("t1_one_done", 64'(done_cnt - dn0), 1);

    // split at the 4 KB boundary
    issue(32'h0FE0, 16'd10);
    wait_done("t2_done", 100);
    chk("t2_nar", 64'(ar_log.size()), 2);
    chk_ar(0, 32'h0FE0, 8'd3);
    chk_ar(1, 32'h1000, 8'd5);
    chk_data("t2", 32'h0FE0, 10);

    // outstanding cap: R held empty, only two bursts may go out
    r_hold = 1'b1;
    issue(32'h2000, 16'd40);
    repeat (20) @(negedge aclk);
    chk("t3_nar_capped", 64'(ar_log.size()), 2);
    chk_ar(0, 32'h2000, 8'd15);
    chk_ar(1, 32'h2080, 8'd15);
    r_hold = 1'b0;
    wait_done("t3_done", 400);
    chk_ar(2, 32'h2100, 8'd7);
    if (ar_log.size() > 2) chk("t3_ar3_after_rlast", 64'(ar_log[2].pops >= 16), 1);
    chk_data("t3", 32'h2000, 40);

    // AR FIFO full mid-command
    issue(32'h3000, 16'd40);
    for (int n = 0; n < 50 && ar_log.size() < 1; n++) @(negedge aclk);
    ar_wr_full = 1'b1;
    repeat (20) @(negedge aclk);
    chk("t4_nar_full", 64'(ar_log.size()), 1);
    chk("t4_hold_addr", 64'(ar_araddr), 64'h3080);
    chk("t4_hold_len", 64'(ar_arlen), 15);
    ar_wr_full = 1'b0;
    wait_done("t4_done", 400);
    chk("t4_no_push_full", 64'(full_viol), 0);
    chk_ar(1, 32'h3080, 8'd15);
    chk_ar(2, 32'h3100, 8'd7);
    chk_data("t4", 32'h3000, 40);

    // back-pressure with an error on beat 2
    err_addr = 32'h4010;
    tog_en = 1'b1;
    issue(32'h4000, 16'd8);
    wait_done("t5_done", 200);
    tog_en = 1'b0;
    chk_data("t5", 32'h4000, 8);
    if (out_log.size() > 3) begin
      chk("t5_err_before_b2", 64'(out_log[2].err_b), 0);
      chk("t5_err_after_b2", 64'(out_log[3].err_b), 1);
    end
    chk("t5_err_done", 64'(err), 1);
    repeat (3) @(negedge aclk);
    chk("t5_err_sticky", 64'(err), 1);
    err_addr = 32'hFFFF_FFFF;

    // zero-beat command: DONE in the cycle after acceptance, err cleared
    issue(32'h5000, 16'd0);
    chk("t6_err_clr", 64'(err), 0);
    chk("t6_done_now", 64'(done), 1);
    wait_done("t6_done", 10);
    chk("t6_nar", 64'(ar_log.size()), 0);
    chk("t6_nbeats", 64'(out_log.size()), 0);

    // reset in mid-burst, then a normal command
    r_hold = 1'b1;
    issue(32'h5000, 16'd40);
    repeat (3) @(negedge aclk);
    aresetn = 1'b0;
    #1;
    chk("t7_arwr", 64'(ar_wr_en), 0);
    chk("t7_oval", 64'(out_valid), 0);
    chk("t7_rden", 64'(r_rd_en), 0);
    chk("t7_busy", 64'(busy), 0);
    chk("t7_done", 64'(done), 0);
    chk("t7_err", 64'(err), 0);
    @(negedge aclk);
    aresetn = 1'b1;
    r_hold = 1'b0;
    issue(32'h6000, 16'd4);
    wait_done("t7_done_after", 100);
    chk("t7_nar", 64'(ar_log.size()), 1);
    chk_ar(0, 32'h6000, 8'd3);
    chk_data("t7", 32'h6000, 4);

    $display("test done: total=%0d bad=%0d", cnt_tot, cnt_bad);
    $finish;
  end

endmodule
